// File: rtl/cpu_arch_reg_bank.sv
// ============================================================================
// cpu_arch_reg_bank : PC / IR / general-register / flag bank with PC-flag shadow
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_arch_reg_bank #(
  parameter int WORD_SIZE     = 19,
  parameter int ADDR_SIZE     = 20,
  parameter int OPCODE_SIZE   = 5,
  parameter int FLAG_REG_SIZE = 4,
  parameter int NUM_GP        = 3,
  parameter int SEL_W         = 3,
  parameter logic [ADDR_SIZE-1:0] PC_RESET = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [SEL_W-1:0]         load_sel,
  input  logic [WORD_SIZE-1:0]     load_data,
  input  logic                     pc_inc,
  input  logic [FLAG_REG_SIZE-1:0] flag_we,
  input  logic [FLAG_REG_SIZE-1:0] flag_in,
  input  logic                     snap,
  input  logic                     restore,
  input  logic [SEL_W-1:0]         rd_sel_a,
  input  logic [SEL_W-1:0]         rd_sel_b,
  output logic [WORD_SIZE-1:0]     rd_data_a,
  output logic [WORD_SIZE-1:0]     rd_data_b,
  output logic [ADDR_SIZE-1:0]     pc_out,
  output logic [WORD_SIZE-1:0]     ir_out,
  output logic [OPCODE_SIZE-1:0]   opcode_out,
  output logic [FLAG_REG_SIZE-1:0] flags_out,
  output logic                     err_bad_sel
);

  localparam int NUM_SEL = NUM_GP + 2;

  if ((1 << SEL_W) < NUM_SEL) begin : g_sel_w_check
    $error("cpu_arch_reg_bank: SEL_W too narrow for NUM_GP+2 selects");
  end

  logic [ADDR_SIZE-1:0]     pc;
  logic [ADDR_SIZE-1:0]     shadow_pc;
  logic [WORD_SIZE-1:0]     ir;
  logic [WORD_SIZE-1:0]     gp [NUM_GP];
  logic [FLAG_REG_SIZE-1:0] flags;
  logic [FLAG_REG_SIZE-1:0] shadow_flags;
  logic                     load_valid;

  assign load_valid = (32'(load_sel) < NUM_SEL);

  // Shadow always captures pre-edge state, so snap+restore together is a swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= PC_RESET;
      shadow_pc    <= PC_RESET;
      ir           <= '0;
      flags        <= '0;
      shadow_flags <= '0;
      err_bad_sel  <= 1'b0;
      for (int k = 0; k < NUM_GP; k++) gp[k] <= '0;
    end else begin
      err_bad_sel <= load_en && !load_valid;

      if (restore)
        pc <= shadow_pc;
      else if (load_en && load_sel == '0)
        pc <= ADDR_SIZE'(load_data);
      else if (pc_inc)
        pc <= pc + ADDR_SIZE'(1);

      if (restore)
        flags <= shadow_flags;
      else
        flags <= (flags & ~flag_we) | (flag_in & flag_we);

      if (snap) begin
        shadow_pc    <= pc;
        shadow_flags <= flags;
      end

      if (load_en && load_sel == SEL_W'(1))
        ir <= load_data;

      for (int k = 0; k < NUM_GP; k++)
        if (load_en && 32'(load_sel) == k + 2) gp[k] <= load_data;
    end
  end

  always_comb begin
    rd_data_a = '0;
    if (rd_sel_a == '0)
      rd_data_a = WORD_SIZE'(pc);
    else if (rd_sel_a == SEL_W'(1))
      rd_data_a = ir;
    for (int k = 0; k < NUM_GP; k++)
      if (32'(rd_sel_a) == k + 2) rd_data_a = gp[k];
  end

  always_comb begin
    rd_data_b = '0;
    if (rd_sel_b == '0)
      rd_data_b = WORD_SIZE'(pc);
    else if (rd_sel_b == SEL_W'(1))
      rd_data_b = ir;
    for (int k = 0; k < NUM_GP; k++)
      if (32'(rd_sel_b) == k + 2) rd_data_b = gp[k];
  end

  assign pc_out     = pc;
  assign ir_out     = ir;
  assign opcode_out = ir[WORD_SIZE-1 -: OPCODE_SIZE];
  assign flags_out  = flags;

endmodule

`default_nettype wire

// File: tb/tb_cpu_arch_reg_bank.sv
// ============================================================================
// tb_cpu_arch_reg_bank : directed self-checking bench for cpu_arch_reg_bank
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_arch_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [2:0]  load_sel = '0;
  logic [18:0] load_data = '0;
  logic        pc_inc = 1'b0;
  logic [3:0]  flag_we = '0;
  logic [3:0]  flag_in = '0;
  logic        snap = 1'b0;
  logic        restore = 1'b0;
  logic [2:0]  rd_sel_a = '0;
  logic [2:0]  rd_sel_b = '0;
  logic [18:0] rd_data_a, rd_data_b;
  logic [19:0] pc_out;
  logic [18:0] ir_out;
  logic [4:0]  opcode_out;
  logic [3:0]  flags_out;
  logic        err_bad_sel;

  // Second instance starts at the top of the PC range to exercise wrap-around.
  logic        pc_inc2 = 1'b0;
  logic        restore2 = 1'b0;
  logic [18:0] rd_data_a2, rd_data_b2;
  logic [19:0] pc_out2;
  logic [18:0] ir_out2;
  logic [4:0]  opcode_out2;
  logic [3:0]  flags_out2;
  logic        err_bad_sel2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_arch_reg_bank u_dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
    .pc_inc(pc_inc), .flag_we(flag_we), .flag_in(flag_in), .snap(snap), .restore(restore),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .pc_out(pc_out), .ir_out(ir_out), .opcode_out(opcode_out), .flags_out(flags_out),
    .err_bad_sel(err_bad_sel)
  );

  cpu_arch_reg_bank #(.PC_RESET(20'hFFFFF)) u_dut_wrap (
    .clk(clk), .rst(rst), .load_en(1'b0), .load_sel(3'd0), .load_data(19'd0),
    .pc_inc(pc_inc2), .flag_we(4'd0), .flag_in(4'd0), .snap(1'b0), .restore(restore2),
    .rd_sel_a(3'd0), .rd_sel_b(3'd0), .rd_data_a(rd_data_a2), .rd_data_b(rd_data_b2),
    .pc_out(pc_out2), .ir_out(ir_out2), .opcode_out(opcode_out2), .flags_out(flags_out2),
    .err_bad_sel(err_bad_sel2)
  );

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_en = 1'b0; load_sel = '0; load_data = '0; pc_inc = 1'b0;
    flag_we = '0; flag_in = '0; snap = 1'b0; restore = 1'b0;
    pc_inc2 = 1'b0; restore2 = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] sel, input logic [18:0] data);
    load_en = 1'b1; load_sel = sel; load_data = data;
    tick();
    clear_inputs();
  endtask

  initial begin
    tick();
    check_val("reset_pc", pc_out, 20'h0);
    check_val("reset_ir", ir_out, 19'h0);
    check_val("reset_flags", flags_out, 4'h0);
    check_val("reset_err", err_bad_sel, 1'b0);
    check_val("wrap_reset_pc", pc_out2, 20'hFFFFF);
    rst = 1'b0;
    tick();

    // Loads into GP and IR
    do_load(3'd3, 19'h12345);
    rd_sel_a = 3'd3; #1;
    check_val("gp1_load", rd_data_a, 19'h12345);
    do_load(3'd1, 19'h7A001);
    check_val("ir_load", ir_out, 19'h7A001);
    check_val("opcode", opcode_out, 5'b11110);
    rd_sel_b = 3'd1; #1;
    check_val("rd_b_ir", rd_data_b, 19'h7A001);
    do_load(3'd2, 19'h00011);
    do_load(3'd4, 19'h00022);
    rd_sel_b = 3'd2; #1;
    check_val("gp0_load", rd_data_b, 19'h00011);
    rd_sel_b = 3'd4; #1;
    check_val("gp2_load", rd_data_b, 19'h00022);
    check_val("pc_untouched_by_gp", pc_out, 20'h0);

    // PC load, read through port, load beats increment
    do_load(3'd0, 19'h7FFFF);
    check_val("pc_load", pc_out, 20'h07FFF | 20'h78000);
    rd_sel_a = 3'd0; #1;
    check_val("rd_a_pc", rd_data_a, 19'h7FFFF);
    load_en = 1'b1; load_sel = 3'd0; load_data = 19'h10; pc_inc = 1'b1;
    tick(); clear_inputs();
    check_val("pc_load_over_inc", pc_out, 20'h00010);
    pc_inc = 1'b1; tick(); clear_inputs();
    check_val("pc_inc", pc_out, 20'h00011);

    // PC wrap on the second instance: inc from FFFFF, restore back to FFFFF, inc again
    pc_inc2 = 1'b1; tick(); clear_inputs();
    check_val("wrap_inc1", pc_out2, 20'h00000);
    restore2 = 1'b1; tick(); clear_inputs();
    check_val("wrap_restore", pc_out2, 20'hFFFFF);
    pc_inc2 = 1'b1; tick(); clear_inputs();
    check_val("wrap_inc2", pc_out2, 20'h00000);

    // Per-bit flag update
    flag_we = 4'hF; flag_in = 4'b1010; tick(); clear_inputs();
    check_val("flags_full", flags_out, 4'b1010);
    flag_we = 4'b0011; flag_in = 4'b0101; tick(); clear_inputs();
    check_val("flags_masked", flags_out, 4'b1001);
    check_val("pc_untouched_by_flags", pc_out, 20'h00011);

    // Shadow snapshot, swap and restore
    load_en = 1'b1; load_sel = 3'd0; load_data = 19'h100; flag_we = 4'hF; flag_in = 4'h3;
    tick(); clear_inputs();
    snap = 1'b1; tick(); clear_inputs();
    load_en = 1'b1; load_sel = 3'd0; load_data = 19'h200; flag_we = 4'hF; flag_in = 4'hC;
    tick(); clear_inputs();
    check_val("pre_swap_pc", pc_out, 20'h200);
    snap = 1'b1; restore = 1'b1; tick(); clear_inputs();
    check_val("swap_pc", pc_out, 20'h100);
    check_val("swap_flags", flags_out, 4'h3);
    restore = 1'b1; tick(); clear_inputs();
    check_val("restore_pc", pc_out, 20'h200);
    check_val("restore_flags", flags_out, 4'hC);

    // Bad select: no register change, PC still increments, one-cycle error pulse
    load_en = 1'b1; load_sel = 3'd5; load_data = 19'h55; pc_inc = 1'b1;
    tick(); clear_inputs();
    check_val("bad_err_high", err_bad_sel, 1'b1);
    check_val("bad_pc_inc", pc_out, 20'h201);
    check_val("bad_ir_hold", ir_out, 19'h7A001);
    rd_sel_a = 3'd2; rd_sel_b = 3'd3; #1;
    check_val("bad_gp0_hold", rd_data_a, 19'h00011);
    check_val("bad_gp1_hold", rd_data_b, 19'h12345);
    rd_sel_a = 3'd4; rd_sel_b = 3'd7; #1;
    check_val("bad_gp2_hold", rd_data_a, 19'h00022);
    check_val("rd_invalid_7", rd_data_b, 19'h0);
    rd_sel_b = 3'd5; #1;
    check_val("rd_invalid_5", rd_data_b, 19'h0);
    tick();
    check_val("bad_err_low", err_bad_sel, 1'b0);

    // Snap captures pre-edge PC; restore outranks a same-cycle PC load
    snap = 1'b1; pc_inc = 1'b1; tick(); clear_inputs();
    check_val("snap_inc_pc", pc_out, 20'h202);
    restore = 1'b1; load_en = 1'b1; load_sel = 3'd0; load_data = 19'h33;
    tick(); clear_inputs();
    check_val("restore_over_load", pc_out, 20'h201);

    // Asynchronous reset mid-cycle, observed before the next edge
    do_load(3'd0, 19'h44);
    #3 rst = 1'b1;
    #1;
    check_val("async_pc", pc_out, 20'h0);
    check_val("async_ir", ir_out, 19'h0);
    check_val("async_flags", flags_out, 4'h0);
    for (int s = 2; s <= 4; s++) begin
      rd_sel_a = 3'(s); #1;
      check_val("async_gp", rd_data_a, 19'h0);
    end
    load_en = 1'b1; load_sel = 3'd2; load_data = 19'h7;
    tick(); clear_inputs();
    rst = 1'b0;
    rd_sel_a = 3'd2; #1;
    check_val("reset_discards_write", rd_data_a, 19'h0);
    do_load(3'd0, 19'h44);
    restore = 1'b1; tick(); clear_inputs();
    check_val("shadow_reset_pc", pc_out, 20'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
